// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core types: default widths, reservation-station entry layout and entry states.
// Used by the order manager, the ROB and the reservation station.
package tomasulo_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_TAG_W  = 4;
    localparam int DEF_OP_W   = 6;

    typedef enum logic [1:0] {
        RS_FREE  = 2'd0,
        RS_WAIT  = 2'd1,
        RS_READY = 2'd2
    } rs_state_e;

    typedef struct packed {
        logic                  busy;
        logic [DEF_OP_W-1:0]   op;
        logic [DEF_TAG_W-1:0]  dst;
        logic [DEF_DATA_W-1:0] vj;
        logic [DEF_DATA_W-1:0] vk;
        logic [DEF_TAG_W-1:0]  qj;
        logic [DEF_TAG_W-1:0]  qk;
        logic                  qj_vld;
        logic                  qk_vld;
    } rs_entry_t;

endpackage

// File: rtl/rs_select.sv
// Lowest-index priority picker: one-hot grant, binary index and any-request flag.
module rs_select #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        // Scan downwards so the lowest requesting index is the last (winning) assignment.
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_gnt    = '0;
                o_gnt[i] = 1'b1;
                o_idx    = IDX_W'(i);
                o_any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Tomasulo reservation station: holds renamed ops, snoops the CDB, issues ready ops to one FU.
// Optional macro RS_FLUSH_EN adds a 'flush' input that frees every entry.
module reservation_station
    import tomasulo_pkg::*;
#(
    parameter int NUM_ENTRIES = 4,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TAG_W       = DEF_TAG_W,
    parameter int OP_W        = DEF_OP_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
`ifdef RS_FLUSH_EN
    input  logic                   flush,
`endif
    input  logic                   disp_valid,
    output logic                   disp_ready,
    input  logic [OP_W-1:0]        disp_op,
    input  logic [TAG_W-1:0]       disp_dst,
    input  logic [DATA_W-1:0]      disp_vj,
    input  logic [TAG_W-1:0]       disp_qj,
    input  logic                   disp_qj_vld,
    input  logic [DATA_W-1:0]      disp_vk,
    input  logic [TAG_W-1:0]       disp_qk,
    input  logic                   disp_qk_vld,
    input  logic                   cdb_valid,
    input  logic [TAG_W-1:0]       cdb_tag,
    input  logic [DATA_W-1:0]      cdb_data,
    output logic                   iss_valid,
    input  logic                   iss_ready,
    output logic [OP_W-1:0]        iss_op,
    output logic [DATA_W-1:0]      iss_vj,
    output logic [DATA_W-1:0]      iss_vk,
    output logic [TAG_W-1:0]       iss_dst,
    output logic [NUM_ENTRIES-1:0] busy,
    output logic                   full
);

    localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    rs_state_e         r_state  [NUM_ENTRIES];
    logic [OP_W-1:0]   r_op     [NUM_ENTRIES];
    logic [TAG_W-1:0]  r_dst    [NUM_ENTRIES];
    logic [DATA_W-1:0] r_vj     [NUM_ENTRIES];
    logic [DATA_W-1:0] r_vk     [NUM_ENTRIES];
    logic [TAG_W-1:0]  r_qj     [NUM_ENTRIES];
    logic [TAG_W-1:0]  r_qk     [NUM_ENTRIES];
    logic              r_qj_vld [NUM_ENTRIES];
    logic              r_qk_vld [NUM_ENTRIES];
    logic              r_hold;
    logic [IDX_W-1:0]  r_hold_idx;

    logic                   w_flush;
    logic [NUM_ENTRIES-1:0] w_busy;
    logic [NUM_ENTRIES-1:0] w_ready;
    logic [NUM_ENTRIES-1:0] w_j_hit;
    logic [NUM_ENTRIES-1:0] w_k_hit;
    logic [NUM_ENTRIES-1:0] w_alloc_oh;
    logic [IDX_W-1:0]       w_alloc_idx;
    logic                   w_free_any;
    logic [NUM_ENTRIES-1:0] w_rdy_oh;
    logic [IDX_W-1:0]       w_rdy_idx;
    logic                   w_rdy_any;
    logic [NUM_ENTRIES-1:0] w_iss_oh;
    logic [IDX_W-1:0]       w_iss_idx;
    logic                   w_iss_any;
    logic                   w_iss_fire;
    logic                   w_disp_fire;
    logic                   w_dj_hit;
    logic                   w_dk_hit;

`ifdef RS_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    always_comb begin
        w_busy  = '0;
        w_ready = '0;
        w_j_hit = '0;
        w_k_hit = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_busy[i]  = (r_state[i] != RS_FREE);
            w_ready[i] = (r_state[i] == RS_READY);
            w_j_hit[i] = cdb_valid && (r_state[i] == RS_WAIT) && r_qj_vld[i] && (r_qj[i] == cdb_tag);
            w_k_hit[i] = cdb_valid && (r_state[i] == RS_WAIT) && r_qk_vld[i] && (r_qk[i] == cdb_tag);
        end
    end

    rs_select #(.N(NUM_ENTRIES), .IDX_W(IDX_W)) u_alloc_sel (
        .i_req (~w_busy),
        .o_gnt (w_alloc_oh),
        .o_idx (w_alloc_idx),
        .o_any (w_free_any)
    );

    rs_select #(.N(NUM_ENTRIES), .IDX_W(IDX_W)) u_issue_sel (
        .i_req (w_ready),
        .o_gnt (w_rdy_oh),
        .o_idx (w_rdy_idx),
        .o_any (w_rdy_any)
    );

    // A presented-but-stalled entry stays locked so a lower entry waking up cannot displace it.
    assign w_iss_idx = r_hold ? r_hold_idx : w_rdy_idx;
    assign w_iss_oh  = r_hold ? (NUM_ENTRIES'(1) << r_hold_idx) : w_rdy_oh;
    assign w_iss_any = r_hold | w_rdy_any;

    assign busy        = w_busy;
    assign full        = &w_busy;
    assign disp_ready  = ~full;
    assign w_disp_fire = disp_valid && disp_ready && w_free_any && !w_flush;
    assign w_dj_hit    = cdb_valid && disp_qj_vld && (disp_qj == cdb_tag);
    assign w_dk_hit    = cdb_valid && disp_qk_vld && (disp_qk == cdb_tag);

    assign iss_valid  = w_iss_any && !w_flush;
    assign w_iss_fire = iss_valid && iss_ready;
    assign iss_op     = iss_valid ? r_op[w_iss_idx] : '0;
    assign iss_vj     = iss_valid ? r_vj[w_iss_idx] : '0;
    assign iss_vk     = iss_valid ? r_vk[w_iss_idx] : '0;
    assign iss_dst    = iss_valid ? r_dst[w_iss_idx] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold     <= 1'b0;
            r_hold_idx <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_state[i]  <= RS_FREE;
                r_op[i]     <= '0;
                r_dst[i]    <= '0;
                r_vj[i]     <= '0;
                r_vk[i]     <= '0;
                r_qj[i]     <= '0;
                r_qk[i]     <= '0;
                r_qj_vld[i] <= 1'b0;
                r_qk_vld[i] <= 1'b0;
            end
        end else begin
            r_hold     <= iss_valid && !iss_ready;
            r_hold_idx <= w_iss_idx;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (w_flush) begin
                    r_state[i] <= RS_FREE;
                end else if (w_iss_fire && w_iss_oh[i]) begin
                    r_state[i] <= RS_FREE;
                end else if (r_state[i] == RS_WAIT) begin
                    if (w_j_hit[i]) begin
                        r_vj[i]     <= cdb_data;
                        r_qj_vld[i] <= 1'b0;
                    end
                    if (w_k_hit[i]) begin
                        r_vk[i]     <= cdb_data;
                        r_qk_vld[i] <= 1'b0;
                    end
                    if (!(r_qj_vld[i] && !w_j_hit[i]) && !(r_qk_vld[i] && !w_k_hit[i]))
                        r_state[i] <= RS_READY;
                end
            end
            // Allocated entry is FREE, so it never collides with the issue or snoop updates above.
            if (w_disp_fire) begin
                r_op[w_alloc_idx]     <= disp_op;
                r_dst[w_alloc_idx]    <= disp_dst;
                r_qj[w_alloc_idx]     <= disp_qj;
                r_qk[w_alloc_idx]     <= disp_qk;
                r_vj[w_alloc_idx]     <= w_dj_hit ? cdb_data : disp_vj;
                r_vk[w_alloc_idx]     <= w_dk_hit ? cdb_data : disp_vk;
                r_qj_vld[w_alloc_idx] <= disp_qj_vld && !w_dj_hit;
                r_qk_vld[w_alloc_idx] <= disp_qk_vld && !w_dk_hit;
                r_state[w_alloc_idx]  <= ((disp_qj_vld && !w_dj_hit) || (disp_qk_vld && !w_dk_hit))
                                         ? RS_WAIT : RS_READY;
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed scenarios plus random traffic against an entry-list model.
module tb_reservation_station;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TW = 4;
    localparam int OW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          disp_valid, disp_ready, disp_qj_vld, disp_qk_vld;
    logic [OW-1:0] disp_op;
    logic [TW-1:0] disp_dst, disp_qj, disp_qk, cdb_tag, iss_dst;
    logic [DW-1:0] disp_vj, disp_vk, cdb_data, iss_vj, iss_vk;
    logic          cdb_valid, iss_valid, iss_ready, full;
    logic [OW-1:0] iss_op;
    logic [N-1:0]  busy;
`ifdef RS_FLUSH_EN
    logic          flush;
`endif

    always #5 clk = ~clk;

    reservation_station #(.NUM_ENTRIES(N), .DATA_W(DW), .TAG_W(TW), .OP_W(OW)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef RS_FLUSH_EN
        .flush(flush),
`endif
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op), .disp_dst(disp_dst),
        .disp_vj(disp_vj), .disp_qj(disp_qj), .disp_qj_vld(disp_qj_vld),
        .disp_vk(disp_vk), .disp_qk(disp_qk), .disp_qk_vld(disp_qk_vld),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op), .iss_vj(iss_vj),
        .iss_vk(iss_vk), .iss_dst(iss_dst), .busy(busy), .full(full)
    );

    typedef struct {
        bit          busy;
        bit [OW-1:0] op;
        bit [TW-1:0] dst;
        bit [DW-1:0] vj, vk;
        bit [TW-1:0] qj, qk;
        bit          qjv, qkv;
    } ment_t;

    ment_t m [N];
    bit    m_hold;
    int    m_hold_idx;
    int    e_idx;
    bit    e_valid;
    int    checks = 0;
    int    fails  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit flushing();
`ifdef RS_FLUSH_EN
        return flush;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) m[i] = '{default: '0};
        m_hold = 0;
    endtask

    task automatic idle();
        disp_valid = 0; cdb_valid = 0;
`ifdef RS_FLUSH_EN
        flush = 0;
`endif
    endtask

    task automatic disp(input int op, input int dst, input int vj, input int qj, input bit qjv,
                        input int vk, input int qk, input bit qkv);
        disp_valid = 1; disp_op = OW'(op); disp_dst = TW'(dst);
        disp_vj = DW'(vj); disp_qj = TW'(qj); disp_qj_vld = qjv;
        disp_vk = DW'(vk); disp_qk = TW'(qk); disp_qk_vld = qkv;
    endtask

    task automatic cdb(input int tag, input int data);
        cdb_valid = 1; cdb_tag = TW'(tag); cdb_data = DW'(data);
    endtask

    // Compare DUT outputs against the model between edges.
    task automatic cyc_a();
        bit [N-1:0] eb;
        @(negedge clk);
        for (int i = 0; i < N; i++) eb[i] = m[i].busy;
        e_idx = -1;
        if (m_hold) e_idx = m_hold_idx;
        else for (int i = N - 1; i >= 0; i--) if (m[i].busy && !m[i].qjv && !m[i].qkv) e_idx = i;
        e_valid = (e_idx >= 0) && !flushing();
        chk("busy", busy, eb);
        chk("full", full, &eb);
        chk("disp_ready", disp_ready, !(&eb));
        chk("iss_valid", iss_valid, e_valid);
        if (e_valid) begin
            chk("iss_op", iss_op, m[e_idx].op);
            chk("iss_vj", iss_vj, m[e_idx].vj);
            chk("iss_vk", iss_vk, m[e_idx].vk);
            chk("iss_dst", iss_dst, m[e_idx].dst);
        end
    endtask

    // Advance the model across the clock edge using the inputs that were presented.
    task automatic cyc_b();
        int  a;
        bit  fire;
        @(posedge clk);
        fire = e_valid && iss_ready;
        if (flushing()) begin
            model_clear();
        end else begin
            a = -1;
            for (int i = N - 1; i >= 0; i--) if (!m[i].busy) a = i;
            for (int i = 0; i < N; i++) begin
                if (m[i].busy && cdb_valid && m[i].qjv && m[i].qj == cdb_tag) begin
                    m[i].vj = cdb_data; m[i].qjv = 0;
                end
                if (m[i].busy && cdb_valid && m[i].qkv && m[i].qk == cdb_tag) begin
                    m[i].vk = cdb_data; m[i].qkv = 0;
                end
            end
            if (fire) m[e_idx].busy = 0;
            m_hold     = e_valid && !iss_ready;
            m_hold_idx = e_idx;
            if (disp_valid && a >= 0) begin
                m[a].busy = 1; m[a].op = disp_op; m[a].dst = disp_dst;
                m[a].qj = disp_qj; m[a].qk = disp_qk;
                m[a].qjv = disp_qj_vld; m[a].qkv = disp_qk_vld;
                m[a].vj = disp_vj; m[a].vk = disp_vk;
                if (cdb_valid && disp_qj_vld && disp_qj == cdb_tag) begin
                    m[a].qjv = 0; m[a].vj = cdb_data;
                end
                if (cdb_valid && disp_qk_vld && disp_qk == cdb_tag) begin
                    m[a].qkv = 0; m[a].vk = cdb_data;
                end
            end
        end
        #1;
    endtask

    task automatic cyc();
        cyc_a();
        cyc_b();
    endtask

    // Reset asserted between edges must clear the station without waiting for a clock.
    task automatic mid_reset();
        idle();
        #2 rst_n = 0;
        #1;
        chk("async_rst_busy", busy, '0);
        chk("async_rst_iss_valid", iss_valid, 0);
        chk("async_rst_full", full, 0);
        model_clear();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 0; iss_ready = 0;
        disp_op = '0; disp_dst = '0; disp_vj = '0; disp_vk = '0; disp_qj = '0; disp_qk = '0;
        disp_qj_vld = 0; disp_qk_vld = 0; cdb_tag = '0; cdb_data = '0;
        idle();
        model_clear();
        #12;
        chk("rst_busy", busy, '0);
        chk("rst_full", full, 0);
        chk("rst_disp_ready", disp_ready, 1);
        chk("rst_iss_valid", iss_valid, 0);
        chk("rst_iss_vj", iss_vj, 0);
        chk("rst_iss_dst", iss_dst, 0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        // Ready-at-dispatch issues the next cycle and frees its entry.
        iss_ready = 1;
        disp(3, 5, 10, 0, 0, 20, 0, 0);
        cyc();
        idle();
        cyc_a();
        chk("t1_valid", iss_valid, 1);
        chk("t1_vj", iss_vj, 10);
        chk("t1_vk", iss_vk, 20);
        chk("t1_dst", iss_dst, 5);
        cyc_b();
        cyc_a();
        chk("t1_freed", busy, '0);
        cyc_b();

        // Pending j woken by a later broadcast.
        disp(1, 6, 0, 7, 1, 33, 0, 0);
        cyc();
        idle();
        cyc();
        cyc_a();
        chk("t2_early", iss_valid, 0);
        cyc_b();
        cdb(7, 'hAB);
        cyc();
        idle();
        cyc_a();
        chk("t2_valid", iss_valid, 1);
        chk("t2_vj", iss_vj, 'hAB);
        cyc_b();

        // Broadcast racing the dispatch of its consumer.
        disp(2, 3, 1, 0, 0, 0, 2, 1);
        cdb(2, 'h55);
        cyc();
        idle();
        cyc_a();
        chk("t3_valid", iss_valid, 1);
        chk("t3_vk", iss_vk, 'h55);
        cyc_b();
        cyc();

        // Fill, overflow attempt, out-of-order wakeup.
        iss_ready = 0;
        for (int i = 0; i < N; i++) begin
            disp(i, i + 1, 0, 8 + i, 1, 0, 0, 0);
            cyc();
        end
        disp(9, 15, 0, 12, 1, 0, 0, 0);
        cyc_a();
        chk("t4_full", full, 1);
        chk("t4_disp_ready", disp_ready, 0);
        cyc_b();
        idle();
        cdb(10, 'h77);
        cyc();
        idle();
        cyc_a();
        chk("t4_first", iss_dst, 3);
        cyc_b();
        iss_ready = 1;
        cyc();

        // Stall with entries 0 and 1 ready: entry 0 held, entry 1 next.
        iss_ready = 0;
        cdb(8, 'h11);
        cyc();
        cdb(9, 'h22);
        cyc();
        idle();
        for (int i = 0; i < 3; i++) begin
            cyc_a();
            chk("t5_hold_dst", iss_dst, 1);
            chk("t5_hold_vj", iss_vj, 'h11);
            cyc_b();
        end
        iss_ready = 1;
        cyc();
        cyc_a();
        chk("t5_next_dst", iss_dst, 2);
        cyc_b();

        // Entry 3 still waits on tag 11; reset mid-run drops it.
        mid_reset();
        cdb(11, 'h33);
        cyc();
        idle();
        cyc_a();
        chk("t6_no_issue", iss_valid, 0);
        cyc_b();

`ifdef RS_FLUSH_EN
        iss_ready = 0;
        for (int i = 0; i < 3; i++) begin
            disp(i, i, 0, 4, 1, 0, 0, 0);
            cyc();
        end
        idle();
        flush = 1;
        disp(7, 7, 1, 0, 0, 2, 0, 0);
        cyc();
        idle();
        cyc_a();
        chk("t7_flush_busy", busy, '0);
        chk("t7_flush_valid", iss_valid, 0);
        cyc_b();
`endif

        // Random traffic with a small tag space so wakeups and races are frequent.
        for (int c = 0; c < 2000; c++) begin
            idle();
            if ($urandom_range(0, 99) < 60)
                disp($urandom_range(0, 63), $urandom_range(0, 15), $urandom, $urandom_range(0, 7),
                     $urandom_range(0, 1), $urandom, $urandom_range(0, 7), $urandom_range(0, 1));
            if ($urandom_range(0, 99) < 50) cdb($urandom_range(0, 7), $urandom);
            iss_ready = ($urandom_range(0, 99) < 65);
`ifdef RS_FLUSH_EN
            flush = ($urandom_range(0, 99) < 2);
`endif
            if (c == 1000) mid_reset();
            else cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
